// File: rtl/pdp_fp17_pkg.sv
// Shared fp17 definitions for the PDP lane reduce datapath.
// Field widths, operation encodings, special values and helpers.
package pdp_fp17_pkg;

    localparam int FP17_W = 17;
    localparam int EXP_W  = 6;
    localparam int MAN_W  = 10;

    typedef enum logic [1:0] {
        PDP_OP_ADD  = 2'd0,
        PDP_OP_MAX  = 2'd1,
        PDP_OP_MIN  = 2'd2,
        PDP_OP_PASS = 2'd3
    } pdp_op_e;

    localparam logic [FP17_W-1:0] FP17_POS_ZERO = 17'h00000;
    localparam logic [FP17_W-1:0] FP17_NEG_ZERO = 17'h10000;
    localparam logic [FP17_W-1:0] FP17_QNAN     = 17'h0FE00;
    localparam logic [EXP_W-1:0]  FP17_EXP_MAX  = 6'h3f;

    function automatic logic fp17_is_nan(input logic [FP17_W-1:0] v);
        return (v[15:10] == FP17_EXP_MAX) && (v[MAN_W-1:0] != '0);
    endfunction

    function automatic logic fp17_is_zero(input logic [FP17_W-1:0] v);
        return v[15:0] == '0;
    endfunction

endpackage

// File: rtl/fp17_add.sv
// fp17 adder core, one output register with valid/ready handshake.
// Ports: clk, rst_n (sync), in_vld/in_rdy/a/b, out_vld/out_rdy/out_dp.
module fp17_add
    import pdp_fp17_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [FP17_W-1:0] a,
    input  logic [FP17_W-1:0] b,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [FP17_W-1:0] out_dp
);

    logic [FP17_W-1:0] x, y, sum;
    logic [EXP_W-1:0]  ex, ey, d, e;
    logic [13:0]       mx, my, sl;
    logic [14:0]       s;
    logic [3:0]        lz;
    logic [MAN_W-1:0]  man;
    logic              swap, uf, of;
    logic              unused_ok;

    // x carries the larger magnitude so the mantissa difference never goes negative
    assign swap = b[15:0] > a[15:0];
    assign x    = swap ? b : a;
    assign y    = swap ? a : b;
    assign ex   = x[15:10];
    assign ey   = y[15:10];
    assign d    = ex - ey;
    assign mx   = {1'b1, x[9:0], 3'b000};
    assign my   = {1'b1, y[9:0], 3'b000} >> d;
    assign s    = (x[16] == y[16]) ? ({1'b0, mx} + {1'b0, my})
                                   : ({1'b0, mx} - {1'b0, my});

    always_comb begin
        lz = '0;
        for (int i = 0; i < 14; i++) begin
            if (s[i]) lz = 4'(13 - i);
        end
    end

    assign sl  = s[13:0] << lz;
    assign man = s[14] ? s[13:4] : sl[12:3];
    assign e   = s[14] ? ex + 6'd1 : ex - {2'b00, lz};
    assign uf  = !s[14] && ({2'b00, lz} >= ex);
    assign of  = s[14] && (ex == 6'h3e);
    assign unused_ok = ^{sl[13], sl[2:0]};

    // exponent 0 is treated as zero, so x + 0 returns x (with -0 folded to +0)
    always_comb begin
        if (fp17_is_nan(a))
            sum = a;
        else if (fp17_is_nan(b))
            sum = b;
        else if (a[15:10] == FP17_EXP_MAX)
            sum = (b[15:10] == FP17_EXP_MAX && a[16] != b[16]) ? FP17_QNAN : a;
        else if (b[15:10] == FP17_EXP_MAX)
            sum = b;
        else if (b[15:10] == '0)
            sum = fp17_is_zero(a) ? FP17_POS_ZERO : a;
        else if (a[15:10] == '0)
            sum = b;
        else if (s == '0 || uf)
            sum = FP17_POS_ZERO;
        else if (of)
            sum = {x[16], FP17_EXP_MAX, 10'h000};
        else
            sum = {x[16], e, man};
    end

    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n)
            out_vld <= 1'b0;
        else if (in_rdy)
            out_vld <= in_vld;
    end

    always_ff @(posedge clk) begin
        if (in_vld && in_rdy)
            out_dp <= sum;
    end

endmodule

// File: rtl/pdp_fp17_cmp.sv
// Combinational single-lane fp17 MAX / MIN / PASS with NaN and signed-zero rules.
// Ports: a, b, mode, mask in; res out (a when masked, PASS or ADD).
module pdp_fp17_cmp
    import pdp_fp17_pkg::*;
(
    input  logic [FP17_W-1:0] a,
    input  logic [FP17_W-1:0] b,
    input  pdp_op_e           mode,
    input  logic              mask,
    output logic [FP17_W-1:0] res
);

    logic a_gt_b;
    logic is_max;
    logic both_zero;

    assign is_max    = (mode == PDP_OP_MAX);
    assign both_zero = fp17_is_zero(a) && fp17_is_zero(b);

    // sign-magnitude ordering; for negatives the larger magnitude is smaller
    always_comb begin
        if (a[16] != b[16])
            a_gt_b = !a[16];
        else if (!a[16])
            a_gt_b = a[15:0] > b[15:0];
        else
            a_gt_b = a[15:0] < b[15:0];
    end

    always_comb begin
        res = a;
        if (mask && (mode == PDP_OP_MAX || mode == PDP_OP_MIN)) begin
            if (fp17_is_nan(a))
                res = a;
            else if (fp17_is_nan(b))
                res = b;
            else if (both_zero)
                res = {is_max ? (a[16] & b[16]) : (a[16] | b[16]), 16'h0000};
            else
                res = (a_gt_b == is_max) ? a : b;
        end
    end

endmodule

// File: rtl/pdp_fp17_lane_reduce.sv
// Per-lane fp17 ADD/MAX/MIN/PASS over LANES lanes with a credit-gated output FIFO.
// Ports: in_pvld/in_prdy/in_a/in_b/in_mode/in_mask, out_pvld/out_prdy/out_dp/out_mode, idle.
module pdp_fp17_lane_reduce
    import pdp_fp17_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DEPTH = 4
)(
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic                    in_pvld,
    output logic                    in_prdy,
    input  logic [LANES*FP17_W-1:0] in_a,
    input  logic [LANES*FP17_W-1:0] in_b,
    input  logic [1:0]              in_mode,
    input  logic [LANES-1:0]        in_mask,
    output logic                    out_pvld,
    input  logic                    out_prdy,
    output logic [LANES*FP17_W-1:0] out_dp,
    output logic [1:0]              out_mode,
    output logic                    idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = LANES * FP17_W;

    pdp_op_e          mode, last_mode, cmp_mode, wr_mode;
    logic             accept, mode_stall, credit_ok, add_ok;
    logic [PW:0]      inflight, count;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LANES-1:0] add_in_rdy, add_out_vld;
    logic             add_join, add_vld;
    logic [DW-1:0]    add_dp, cmp_res, cmp_dp, wr_dp;
    logic             cmp_vld, wr_en, rd_en;
    logic [DW-1:0]    mem_dp [DEPTH];
    pdp_op_e          mem_mode [DEPTH];

    assign mode       = pdp_op_e'(in_mode);
    assign credit_ok  = ({1'b0, inflight} + {1'b0, count}) < (PW+2)'(DEPTH);
    // the adder and register paths must not overtake each other
    assign mode_stall = (mode != last_mode) && (inflight != '0);
    assign add_ok     = (mode != PDP_OP_ADD) || (&add_in_rdy);
    assign in_prdy    = !nvdla_core_rst && credit_ok && !mode_stall && add_ok;
    assign accept     = in_pvld && in_prdy;
    assign add_vld    = accept && (mode == PDP_OP_ADD);
    assign add_join   = &add_out_vld;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp17_add u_add (
            .clk     (nvdla_core_clk),
            .rst_n   (~nvdla_core_rst),
            .in_vld  (add_vld),
            .in_rdy  (add_in_rdy[i]),
            .a       (in_a[i*FP17_W +: FP17_W]),
            .b       (in_mask[i] ? in_b[i*FP17_W +: FP17_W] : FP17_POS_ZERO),
            .out_vld (add_out_vld[i]),
            .out_rdy (add_join),
            .out_dp  (add_dp[i*FP17_W +: FP17_W])
        );

        pdp_fp17_cmp u_cmp (
            .a    (in_a[i*FP17_W +: FP17_W]),
            .b    (in_b[i*FP17_W +: FP17_W]),
            .mode (mode),
            .mask (in_mask[i]),
            .res  (cmp_res[i*FP17_W +: FP17_W])
        );
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst)
            cmp_vld <= 1'b0;
        else
            cmp_vld <= accept && (mode != PDP_OP_ADD);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (accept) begin
            cmp_dp   <= cmp_res;
            cmp_mode <= mode;
        end
    end

    // mode_stall keeps both paths from writing in the same cycle
    assign wr_en   = cmp_vld || add_join;
    assign wr_dp   = add_join ? add_dp : cmp_dp;
    assign wr_mode = add_join ? PDP_OP_ADD : cmp_mode;
    assign rd_en   = out_pvld && out_prdy;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            inflight  <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_mode <= PDP_OP_ADD;
        end else begin
            if (accept)
                last_mode <= mode;
            inflight <= inflight + (PW+1)'(accept) - (PW+1)'(wr_en);
            count    <= count + (PW+1)'(wr_en) - (PW+1)'(rd_en);
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (wr_en) begin
            mem_dp[wr_ptr]   <= wr_dp;
            mem_mode[wr_ptr] <= wr_mode;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rst)
            assert (!(wr_en && !rd_en && count == (PW+1)'(DEPTH)));
    end

    assign out_pvld = (count != '0);
    assign out_dp   = mem_dp[rd_ptr];
    assign out_mode = mem_mode[rd_ptr];
    assign idle     = (inflight == '0) && (count == '0);

endmodule

// File: tb/tb_pdp_fp17_lane_reduce.sv
// Directed bench for pdp_fp17_lane_reduce: vector table plus
// backpressure, mode-ordering and mid-flight reset sequences.
module tb_pdp_fp17_lane_reduce;

    logic        clk;
    logic        rst;
    logic        in_pvld;
    logic        in_prdy;
    logic [67:0] in_a;
    logic [67:0] in_b;
    logic [1:0]  in_mode;
    logic [3:0]  in_mask;
    logic        out_pvld;
    logic        out_prdy;
    logic [67:0] out_dp;
    logic [1:0]  out_mode;
    logic        idle;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  mask;
        logic [67:0] a;
        logic [67:0] b;
        logic [67:0] exp_dp;
    } vec_t;

    vec_t vecs [7];

    pdp_fp17_lane_reduce #(.LANES(4), .DEPTH(4)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .in_pvld        (in_pvld),
        .in_prdy        (in_prdy),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_mode        (in_mode),
        .in_mask        (in_mask),
        .out_pvld       (out_pvld),
        .out_prdy       (out_prdy),
        .out_dp         (out_dp),
        .out_mode       (out_mode),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [67:0] act,
                         input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int k);
        in_mode = vecs[k].mode;
        in_mask = vecs[k].mask;
        in_a    = vecs[k].a;
        in_b    = vecs[k].b;
    endtask

    function automatic logic [67:0] beat_a(input int k);
        logic [67:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            v[i*17 +: 17] = 17'h00400 + 17'(k * 16 + i);
        return v;
    endfunction

    task automatic run_vec(input int k);
        int w;
        int lat;
        @(negedge clk);
        in_pvld = 1'b1;
        drive(k);
        #1;
        w = 0;
        while (!in_prdy && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check($sformatf("v%0d_accept", k), in_prdy, 1);
        @(posedge clk);
        #1;
        in_pvld = 1'b0;
        lat = 0;
        while (!out_pvld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d_latency", k), lat, 2);
        check($sformatf("v%0d_dp", k), out_dp, vecs[k].exp_dp);
        check($sformatf("v%0d_mode", k), out_mode, vecs[k].mode);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_idle", k), idle, 1);
    endtask

    initial begin
        int tx;
        int rx;
        int w;
        logic acc;
        logic rd;

        vecs[0] = '{2'd1, 4'hf,
            {17'h10000, 17'h00000, 17'h1F000, 17'h0F000},
            {17'h00000, 17'h10000, 17'h0F000, 17'h0E000},
            {17'h00000, 17'h00000, 17'h0F000, 17'h0F000}};
        vecs[1] = '{2'd2, 4'hf,
            {17'h00400, 17'h0F000, 17'h00000, 17'h0FC01},
            {17'h0FC02, 17'h1F000, 17'h10000, 17'h00400},
            {17'h0FC02, 17'h1F000, 17'h10000, 17'h0FC01}};
        vecs[2] = '{2'd0, 4'b0101,
            {4{17'h03C00}},
            {4{17'h03C00}},
            {17'h03C00, 17'h04000, 17'h03C00, 17'h04000}};
        vecs[3] = '{2'd3, 4'hf,
            {17'h00000, 17'h0FC01, 17'h1ABCD, 17'h01234},
            {4{17'h05555}},
            {17'h00000, 17'h0FC01, 17'h1ABCD, 17'h01234}};
        vecs[4] = '{2'd1, 4'b0011,
            {17'h10000, 17'h03C00, 17'h1FC05, 17'h03C00},
            {17'h00000, 17'h04000, 17'h00000, 17'h04000},
            {17'h10000, 17'h03C00, 17'h1FC05, 17'h04000}};
        vecs[5] = '{2'd0, 4'hf,
            {17'h03C00, 17'h04000, 17'h10000, 17'h03C00},
            {17'h03E00, 17'h13C00, 17'h10000, 17'h13C00},
            {17'h04100, 17'h03C00, 17'h00000, 17'h00000}};
        vecs[6] = '{2'd2, 4'hf,
            {17'h10000, 17'h00000, 17'h1F000, 17'h04000},
            {17'h00000, 17'h00000, 17'h1E000, 17'h03C00},
            {17'h10000, 17'h00000, 17'h1F000, 17'h03C00}};

        rst      = 1'b1;
        in_pvld  = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_mode  = 2'd0;
        in_mask  = '0;
        out_prdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_pvld", out_pvld, 0);
        check("rst_idle", idle, 1);
        check("rst_in_prdy", in_prdy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_prdy", in_prdy, 1);
        check("post_rst_idle", idle, 1);

        for (int k = 0; k < 7; k++)
            run_vec(k);

        // backpressure: six MAX beats against a stalled output
        out_prdy = 1'b0;
        tx = 0;
        rx = 0;
        for (int c = 0; c < 80 && rx < 6; c++) begin
            @(negedge clk);
            if (c == 20) begin
                check("s1_accepted", tx, 4);
                check("s1_in_prdy_full", in_prdy, 0);
                out_prdy = 1'b1;
            end
            in_pvld = (tx < 6);
            in_mode = 2'd1;
            in_mask = 4'hf;
            in_a    = beat_a(tx);
            in_b    = '0;
            #1;
            acc = in_pvld && in_prdy;
            rd  = out_pvld && out_prdy;
            if (rd)
                check($sformatf("s1_out%0d", rx), out_dp, beat_a(rx));
            @(posedge clk);
            if (acc) tx++;
            if (rd) rx++;
        end
        #1;
        in_pvld = 1'b0;
        check("s1_delivered", rx, 6);
        check("s1_sent", tx, 6);

        // ADD immediately followed by MAX must stall until ADD is written
        @(negedge clk);
        in_pvld = 1'b1;
        drive(2);
        #1;
        check("s2_add_rdy", in_prdy, 1);
        @(posedge clk);
        @(negedge clk);
        drive(0);
        #1;
        check("s2_stall", in_prdy, 0);
        w = 0;
        while (!in_prdy && w < 10) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("s2_stall_len", w, 1);
        check("s2_first_vld", out_pvld, 1);
        check("s2_first_mode", out_mode, 0);
        check("s2_first_dp", out_dp, vecs[2].exp_dp);
        @(posedge clk);
        #1;
        in_pvld = 1'b0;
        w = 0;
        @(negedge clk);
        while (!out_pvld && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("s2_second_mode", out_mode, 1);
        check("s2_second_dp", out_dp, vecs[0].exp_dp);
        @(posedge clk);

        // reset with three beats outstanding
        out_prdy = 1'b0;
        tx = 0;
        for (int c = 0; c < 10 && tx < 3; c++) begin
            @(negedge clk);
            in_pvld = 1'b1;
            in_mode = 2'd1;
            in_mask = 4'hf;
            in_a    = beat_a(tx);
            in_b    = '0;
            #1;
            acc = in_prdy;
            @(posedge clk);
            if (acc) tx++;
        end
        @(negedge clk);
        in_pvld = 1'b0;
        check("s3_sent", tx, 3);
        check("s3_busy", idle, 0);
        rst = 1'b1;
        @(negedge clk);
        check("s3_out_pvld", out_pvld, 0);
        check("s3_idle", idle, 1);
        rst = 1'b0;
        out_prdy = 1'b1;
        run_vec(0);
        @(negedge clk);
        check("s3_empty_after", out_pvld, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
